// File: rtl/mm_tile_scheduler.sv
// Tile scheduler for one tiled M x K x N matmul through mm_unit: issues A/B tile reads, drains, pulses done.
// Optional k-step zero skipping is compiled in with `define SCHED_ZERO_SKIP_EN.
module mm_tile_scheduler #(
  parameter int M         = 16,
  parameter int K         = 16,
  parameter int N         = 16,
  parameter int M_TILE    = 4,
  parameter int K_TILE    = 4,
  parameter int N_TILE    = 4,
  parameter int DW_INT    = 8,
  parameter int AW        = 8,
  parameter int DRAIN_CYC = 6,
  localparam int MT       = M / M_TILE,
  localparam int KT       = K / K_TILE,
  localparam int NT       = N / N_TILE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stall,
  input  logic [KT-1:0]     i_skip_mask,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_a_rd_en,
  output logic [AW-1:0]     o_a_rd_addr,
  output logic              o_b_rd_en,
  output logic [AW-1:0]     o_b_rd_addr,
  output logic              o_mm_enable,
  output logic [DW_INT-1:0] o_mm_ptr_m,
  output logic [DW_INT-1:0] o_mm_ptr_n,
  output logic [1:0]        o_mm_in_valid,
  output logic [1:0]        o_dbg_state
);

  localparam int MW  = (MT > 1) ? $clog2(MT) : 1;
  localparam int NW  = (NT > 1) ? $clog2(NT) : 1;
  localparam int KW  = (KT > 1) ? $clog2(KT) : 1;
  localparam int DCW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MW-1:0]     r_m;
  logic [NW-1:0]     r_n;
  logic [KW-1:0]     r_k;
  logic [DCW-1:0]    r_drain;
  logic              r_mm_enable;
  logic [1:0]        r_mm_in_valid;
  logic [DW_INT-1:0] r_mm_ptr_m;
  logic [DW_INT-1:0] r_mm_ptr_n;

  logic [KT-1:0]     w_mask;
  logic [KT-1:0]     w_start_mask;
  logic [KW-1:0]     w_k_next;
  logic              w_k_has_next;
  logic              w_busy;
  logic              w_issue;
  logic              w_last_n;
  logic              w_last_m;
  logic              w_last_issue;
  logic              w_drain_end;

`ifdef SCHED_ZERO_SKIP_EN
  logic [KT-1:0]     r_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_mask <= i_skip_mask;
    end
  end

  assign w_start_mask = i_skip_mask;
  assign w_mask       = r_mask;
`else
  logic w_unused_skip;
  assign w_unused_skip = ^i_skip_mask;
  assign w_start_mask  = '0;
  assign w_mask        = '0;
`endif

  // Lowest k-step not flagged as all-zero; 0 when every step is masked.
  function automatic logic [KW-1:0] f_first(input logic [KT-1:0] mask);
    f_first = '0;
    for (int i = KT - 1; i >= 0; i--) begin
      if (!mask[i]) f_first = KW'(i);
    end
  endfunction

  always_comb begin
    w_k_next     = '0;
    w_k_has_next = 1'b0;
    for (int i = KT - 1; i >= 0; i--) begin
      if (!w_mask[i] && (i > int'(r_k))) begin
        w_k_next     = KW'(i);
        w_k_has_next = 1'b1;
      end
    end
  end

  assign w_busy       = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign w_issue      = (r_state == ST_ISSUE) && !i_stall;
  assign w_last_n     = (r_n == NW'(NT - 1));
  assign w_last_m     = (r_m == MW'(MT - 1));
  assign w_last_issue = w_issue && !w_k_has_next && w_last_n && w_last_m;
  assign w_drain_end  = (r_state == ST_DRAIN) && !i_stall &&
                        (r_drain == DCW'(DRAIN_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = (&w_start_mask) ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE: if (w_last_issue) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Walk order is k fastest, then n, then m; counters return to 0 after the last issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= f_first(w_start_mask);
    end else if (w_issue) begin
      if (w_k_has_next) begin
        r_k <= w_k_next;
      end else begin
        r_k <= (w_last_n && w_last_m) ? '0 : f_first(w_mask);
        if (w_last_n) begin
          r_n <= '0;
          r_m <= w_last_m ? '0 : r_m + 1'b1;
        end else begin
          r_n <= r_n + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drain <= '0;
    end else if (r_state == ST_DRAIN && !i_stall) begin
      r_drain <= w_drain_end ? '0 : r_drain + 1'b1;
    end
  end

  // Read data returns one cycle after the issue, so mm_unit controls are delayed by one register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mm_enable   <= 1'b0;
      r_mm_in_valid <= 2'b00;
      r_mm_ptr_m    <= '0;
      r_mm_ptr_n    <= '0;
    end else begin
      r_mm_enable   <= w_busy && !i_stall;
      r_mm_in_valid <= {2{w_issue}};
      if (w_issue) begin
        r_mm_ptr_m <= DW_INT'(r_m) * DW_INT'(M_TILE);
        r_mm_ptr_n <= DW_INT'(r_n) * DW_INT'(N_TILE);
      end
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = (r_state == ST_DONE);
  assign o_a_rd_en     = w_issue;
  assign o_b_rd_en     = w_issue;
  assign o_a_rd_addr   = AW'(r_m) * AW'(KT) + AW'(r_k);
  assign o_b_rd_addr   = AW'(r_k) * AW'(NT) + AW'(r_n);
  assign o_mm_enable   = r_mm_enable;
  assign o_mm_ptr_m    = r_mm_ptr_m;
  assign o_mm_ptr_n    = r_mm_ptr_n;
  assign o_mm_in_valid = r_mm_in_valid;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Bench for mm_tile_scheduler: per-cycle traces checked against a tile-walk/timeline model.
// Zero-skip scenarios follow SCHED_ZERO_SKIP_EN when the macro is defined.
module tb_mm_tile_scheduler;

  localparam int MT    = 4;
  localparam int KT    = 4;
  localparam int NT    = 4;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DRAIN = 6;
  localparam int NC    = 200;
  localparam int VW    = 39;
  localparam int RW    = 32;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic          i_stall;
  logic [KT-1:0] i_skip_mask;
  logic          o_busy, o_done, o_a_rd_en, o_b_rd_en, o_mm_enable;
  logic [AW-1:0] o_a_rd_addr, o_b_rd_addr;
  logic [DW-1:0] o_mm_ptr_m, o_mm_ptr_n;
  logic [1:0]    o_mm_in_valid, o_dbg_state;

  int checks = 0;
  int errors = 0;

  logic          stall_pat [NC];
  logic          start_pat [NC];
  logic          reset_pat [NC];
  logic [KT-1:0] run_mask;
  logic [VW-1:0] obs_vec  [NC];
  logic [1:0]    obs_state[NC];
  logic [VW-1:0] exp_vec  [NC];
  logic [VW-1:0] care_vec [NC];
  logic [RW-1:0] exp_q[$];

  mm_tile_scheduler dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stall(i_stall),
    .i_skip_mask(i_skip_mask), .o_busy(o_busy), .o_done(o_done),
    .o_a_rd_en(o_a_rd_en), .o_a_rd_addr(o_a_rd_addr),
    .o_b_rd_en(o_b_rd_en), .o_b_rd_addr(o_b_rd_addr),
    .o_mm_enable(o_mm_enable), .o_mm_ptr_m(o_mm_ptr_m), .o_mm_ptr_n(o_mm_ptr_n),
    .o_mm_in_valid(o_mm_in_valid), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_skip_mask = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_pats();
    for (int c = 0; c < NC; c++) begin
      stall_pat[c] = 1'b0; start_pat[c] = 1'b0; reset_pat[c] = 1'b0;
    end
    start_pat[0] = 1'b1;
    run_mask = '0;
  endtask

  // Driver: cycle 0 is the cycle carrying the start pulse; outputs sampled mid-cycle.
  task automatic run_cycles();
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      reset       = reset_pat[c];
      i_start     = start_pat[c];
      i_stall     = stall_pat[c];
      i_skip_mask = (c == 0) ? run_mask : KT'($urandom);
      #1;
      obs_vec[c]   = {o_a_rd_en, o_b_rd_en, o_a_rd_addr, o_b_rd_addr, o_mm_enable,
                      o_mm_in_valid, o_mm_ptr_m, o_mm_ptr_n, o_busy, o_done};
      obs_state[c] = o_dbg_state;
    end
    @(negedge clk);
    reset = 1'b0; i_start = 1'b0; i_stall = 1'b0;
  endtask

  // Reference model: tile walk list, then a timeline of reads / drain / done under the stall pattern.
  task automatic build_model(input logic [KT-1:0] mask);
    logic [KT-1:0] em;
    int idx, drain_left, done_cyc;
    logic busy, rd, done, busy_p, rd_p, stall_p;
    logic [RW-1:0] val, val_p;
`ifdef SCHED_ZERO_SKIP_EN
    em = mask;
`else
    em = '0;
    if (mask != mask) em = mask;
`endif
    exp_q.delete();
    for (int m = 0; m < MT; m++)
      for (int n = 0; n < NT; n++)
        for (int k = 0; k < KT; k++)
          if (!em[k]) exp_q.push_back({8'(m * KT + k), 8'(k * NT + n), 8'(m * 4), 8'(n * 4)});
    idx = 0; drain_left = DRAIN; done_cyc = -1;
    busy_p = 1'b0; rd_p = 1'b0; stall_p = 1'b0; val_p = '0;
    for (int c = 0; c < NC; c++) begin
      busy = 1'b0; rd = 1'b0; done = 1'b0; val = '0;
      if (c >= 1 && done_cyc < 0) begin
        if (idx < exp_q.size()) begin
          busy = 1'b1;
          if (!stall_pat[c]) begin rd = 1'b1; val = exp_q[idx]; idx++; end
        end else if (drain_left > 0) begin
          busy = 1'b1;
          if (!stall_pat[c]) drain_left--;
        end else begin
          done = 1'b1; done_cyc = c;
        end
      end
      exp_vec[c]  = {rd, rd, val[31:24], val[23:16], busy_p & ~stall_p, {2{rd_p}},
                     val_p[15:8], val_p[7:0], busy, done};
      care_vec[c] = {2'b11, rd ? 16'hffff : 16'h0, 3'b111, rd_p ? 16'hffff : 16'h0, 2'b11};
      busy_p = busy; rd_p = rd; stall_p = stall_pat[c]; val_p = val;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; i_start = 1'b1; i_stall = 1'b0; i_skip_mask = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; i_start = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_a_rd_en, o_b_rd_en, o_a_rd_addr, o_b_rd_addr, o_mm_enable,
         o_mm_ptr_m, o_mm_ptr_n, o_mm_in_valid} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero busy=%b done=%b rd=%b en=%b iv=%b exp all 0",
                         o_busy, o_done, o_a_rd_en, o_mm_enable, o_mm_in_valid);
    end
    checks++;
    if (o_dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", o_dbg_state);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_wins_start busy got %b exp 0", o_busy);
    end
  endtask

  task automatic test_basic();
    int nrd, first_rd, last_rd, done_cyc, ndone, iv_first, iv_last;
    apply_reset(); clear_pats(); run_cycles(); build_model('0);
    for (int c = 0; c < NC; c++) begin
      checks++;
      if ((obs_vec[c] & care_vec[c]) !== (exp_vec[c] & care_vec[c])) begin
        errors++; $display("FAIL basic_trace cycle %0d got %h exp %h", c, obs_vec[c] & care_vec[c], exp_vec[c] & care_vec[c]);
      end
    end
    nrd = 0; first_rd = -1; last_rd = -1; done_cyc = -1; ndone = 0; iv_first = -1; iv_last = -1;
    for (int c = 0; c < NC; c++) begin
      if (obs_vec[c][38]) begin nrd++; if (first_rd < 0) first_rd = c; last_rd = c; end
      if (obs_vec[c][19:18] == 2'b11) begin if (iv_first < 0) iv_first = c; iv_last = c; end
      if (obs_vec[c][0]) begin ndone++; done_cyc = c; end
    end
    checks++; if (nrd !== 64) begin errors++; $display("FAIL basic_read_count got %0d exp 64", nrd); end
    checks++; if (first_rd !== 1 || last_rd !== 64) begin
      errors++; $display("FAIL basic_read_window got %0d-%0d exp 1-64", first_rd, last_rd); end
    checks++; if (iv_first !== 2 || iv_last !== 65) begin
      errors++; $display("FAIL basic_valid_window got %0d-%0d exp 2-65", iv_first, iv_last); end
    checks++; if (done_cyc !== 71 || ndone !== 1) begin
      errors++; $display("FAIL basic_done got cycle %0d count %0d exp cycle 71 count 1", done_cyc, ndone); end
  endtask

  task automatic test_addr_order();
    int ea[5] = '{0, 1, 2, 3, 0};
    int eb[5] = '{0, 4, 8, 12, 1};
    int nrd, rd17_cyc;
    logic [RW-1:0] e;
    apply_reset(); clear_pats(); run_cycles(); build_model('0);
    nrd = 0; rd17_cyc = -1;
    for (int c = 0; c < NC; c++) begin
      if (obs_vec[c][38]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_extra_read cycle %0d got a=%0d b=%0d exp none", c, obs_vec[c][36:29], obs_vec[c][28:21]);
        end else begin
          e = exp_q.pop_front();
          if (obs_vec[c][36:21] !== e[31:16]) begin
            errors++; $display("FAIL sb_addr read %0d got a=%0d b=%0d exp a=%0d b=%0d", nrd,
                               obs_vec[c][36:29], obs_vec[c][28:21], e[31:24], e[23:16]);
          end
        end
        if (nrd < 5) begin
          checks++;
          if (int'(obs_vec[c][36:29]) != ea[nrd] || int'(obs_vec[c][28:21]) != eb[nrd]) begin
            errors++; $display("FAIL first_reads %0d got (%0d,%0d) exp (%0d,%0d)", nrd,
                               obs_vec[c][36:29], obs_vec[c][28:21], ea[nrd], eb[nrd]);
          end
        end
        if (nrd == 16) rd17_cyc = c;
        nrd++;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_missing got %0d left exp 0", exp_q.size()); end
    checks++;
    if (rd17_cyc < 0 || rd17_cyc + 1 >= NC) begin
      errors++; $display("FAIL read17_missing got cycle %0d exp 17", rd17_cyc);
    end else if (obs_vec[rd17_cyc][36:21] !== 16'h0400 || obs_vec[rd17_cyc + 1][17:2] !== 16'h0400) begin
      errors++; $display("FAIL read17 got a=%0d b=%0d ptr_m=%0d ptr_n=%0d exp 4 0 4 0",
                         obs_vec[rd17_cyc][36:29], obs_vec[rd17_cyc][28:21],
                         obs_vec[rd17_cyc + 1][17:10], obs_vec[rd17_cyc + 1][9:2]);
    end
  endtask

  task automatic test_stall();
    int done_cyc;
    apply_reset(); clear_pats();
    for (int c = 10; c <= 12; c++) stall_pat[c] = 1'b1;
    run_cycles(); build_model('0);
    done_cyc = -1;
    for (int c = 0; c < NC; c++) begin
      checks++;
      if ((obs_vec[c] & care_vec[c]) !== (exp_vec[c] & care_vec[c])) begin
        errors++; $display("FAIL stall_trace cycle %0d got %h exp %h", c, obs_vec[c] & care_vec[c], exp_vec[c] & care_vec[c]);
      end
      if (obs_vec[c][0]) done_cyc = c;
    end
    checks++;
    if (done_cyc !== 74) begin errors++; $display("FAIL stall_done got %0d exp 74", done_cyc); end
    checks++;
    if ({obs_vec[10][20], obs_vec[11][20], obs_vec[12][20], obs_vec[13][20], obs_vec[14][20]} !== 5'b10001) begin
      errors++; $display("FAIL stall_enable cycles 10-14 got %b%b%b%b%b exp 10001", obs_vec[10][20],
                         obs_vec[11][20], obs_vec[12][20], obs_vec[13][20], obs_vec[14][20]);
    end
  endtask

  task automatic test_random_stall();
    for (int it = 0; it < 4; it++) begin
      apply_reset(); clear_pats();
      run_mask = KT'($urandom_range(0, 15));
      for (int c = 1; c < 140; c++) stall_pat[c] = ($urandom_range(0, 3) == 0);
      run_cycles(); build_model(run_mask);
      for (int c = 0; c < NC; c++) begin
        checks++;
        if ((obs_vec[c] & care_vec[c]) !== (exp_vec[c] & care_vec[c])) begin
          errors++; $display("FAIL rand_trace iter %0d cycle %0d got %h exp %h", it, c,
                             obs_vec[c] & care_vec[c], exp_vec[c] & care_vec[c]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone, done_cyc;
    apply_reset(); clear_pats();
    start_pat[20] = 1'b1;
    run_cycles(); build_model('0);
    ndone = 0; done_cyc = -1;
    for (int c = 0; c < NC; c++) begin
      checks++;
      if ((obs_vec[c] & care_vec[c]) !== (exp_vec[c] & care_vec[c])) begin
        errors++; $display("FAIL restart_trace cycle %0d got %h exp %h", c, obs_vec[c] & care_vec[c], exp_vec[c] & care_vec[c]);
      end
      if (obs_vec[c][0]) begin ndone++; done_cyc = c; end
    end
    checks++;
    if (ndone !== 1 || done_cyc !== 71) begin
      errors++; $display("FAIL restart_done got count %0d cycle %0d exp 1 at 71", ndone, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    apply_reset(); clear_pats();
    reset_pat[30] = 1'b1;
    run_cycles();
    ndone = 0;
    for (int c = 0; c < NC; c++) if (obs_vec[c][0]) ndone++;
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", ndone); end
    for (int c = 31; c < 60; c++) begin
      checks++;
      if (obs_vec[c] !== '0 || obs_state[c] !== 2'd0) begin
        errors++; $display("FAIL abort_zero cycle %0d got %h state %0d exp 0", c, obs_vec[c], obs_state[c]);
      end
    end
    clear_pats(); run_cycles(); build_model('0);
    for (int c = 0; c < NC; c++) begin
      checks++;
      if ((obs_vec[c] & care_vec[c]) !== (exp_vec[c] & care_vec[c])) begin
        errors++; $display("FAIL abort_rerun cycle %0d got %h exp %h", c, obs_vec[c] & care_vec[c], exp_vec[c] & care_vec[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 2; it++) begin
      clear_pats(); run_cycles(); build_model('0);
      for (int c = 0; c < NC; c++) begin
        checks++;
        if ((obs_vec[c] & care_vec[c]) !== (exp_vec[c] & care_vec[c])) begin
          errors++; $display("FAIL b2b_trace run %0d cycle %0d got %h exp %h", it, c,
                             obs_vec[c] & care_vec[c], exp_vec[c] & care_vec[c]);
        end
      end
    end
  endtask

  task automatic test_zero_skip();
    logic [KT-1:0] masks[2] = '{4'b0101, 4'b1111};
    int nrd, done_cyc, exp_rd, exp_done;
    for (int it = 0; it < 2; it++) begin
      apply_reset(); clear_pats();
      run_mask = masks[it];
      run_cycles(); build_model(run_mask);
`ifdef SCHED_ZERO_SKIP_EN
      exp_rd   = (it == 0) ? 32 : 0;
      exp_done = (it == 0) ? 39 : 7;
`else
      exp_rd   = 64;
      exp_done = 71;
`endif
      nrd = 0; done_cyc = -1;
      for (int c = 0; c < NC; c++) begin
        checks++;
        if ((obs_vec[c] & care_vec[c]) !== (exp_vec[c] & care_vec[c])) begin
          errors++; $display("FAIL skip_trace mask %b cycle %0d got %h exp %h", run_mask, c,
                             obs_vec[c] & care_vec[c], exp_vec[c] & care_vec[c]);
        end
        if (obs_vec[c][38]) nrd++;
        if (obs_vec[c][0]) done_cyc = c;
      end
      checks++;
      if (nrd !== exp_rd || done_cyc !== exp_done) begin
        errors++; $display("FAIL skip_summary mask %b got reads %0d done %0d exp reads %0d done %0d",
                           run_mask, nrd, done_cyc, exp_rd, exp_done);
      end
    end
  endtask

  initial begin
    reset = 1'b0; i_start = 1'b0; i_stall = 1'b0; i_skip_mask = '0;
    test_reset();
    test_basic();
    test_addr_order();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random_stall();
    test_zero_skip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
